// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the PIO instruction-memory loader.
package instr_loader_pkg;

    localparam int IMEM_DEPTH = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 16;
    localparam int MAX_LEN    = IMEM_DEPTH;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        WRITE,
        FLUSH,
        VERIFY
    } loaderState_t;

endpackage

// File: rtl/loader_checksum.sv
// XOR accumulator used to fingerprint the words written and read back by the loader.
module loader_checksum
    import instr_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] sum_o
);

    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            sum_q <= '0;
        end else if (enable_i) begin
            sum_q <= sum_q ^ data_i;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Program-load controller: halts the state machines and streams words into instruction memory.
// Define INSTR_LOADER_VERIFY_EN to add the checksum readback pass (VERIFY state).
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_start,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              sm_halt,
    output logic              done,
    output logic              error
);

    loaderState_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   remain_q;
    logic [ADDR_W-1:0] wrAddr_q;
    logic [DATA_W-1:0] wrData_q;
    logic              wrEn_q;
    logic              done_q;
    logic              error_q;

    logic cmdFire, dataFire, lenIllegal, lastWord, finish, lastRead, mismatch;

    assign cmdFire    = cmd_valid && cmd_ready;
    assign dataFire   = data_valid && data_ready;
    assign lenIllegal = (cmd_len == '0) || (int'(cmd_len) > MAX_LEN);
    assign lastWord   = dataFire && (remain_q == (ADDR_W+1)'(1));

`ifdef INSTR_LOADER_VERIFY_EN
    logic [ADDR_W-1:0] rdAddr_q;
    logic [ADDR_W:0]   rdCnt_q;
    logic [DATA_W-1:0] wrSum, rdSum;

    loader_checksum #(.DATA_W(DATA_W)) u_wrSum (
        .clk     (clk),
        .reset   (reset),
        .clear_i (cmdFire),
        .enable_i(dataFire),
        .data_i  (data_in),
        .sum_o   (wrSum)
    );

    loader_checksum #(.DATA_W(DATA_W)) u_rdSum (
        .clk     (clk),
        .reset   (reset),
        .clear_i (cmdFire),
        .enable_i(state_q == VERIFY),
        .data_i  (mem_rd_data),
        .sum_o   (rdSum)
    );

    // Readback pointer is armed at command accept and only moves during VERIFY
    always_ff @(posedge clk) begin
        if (reset) begin
            rdAddr_q <= '0;
            rdCnt_q  <= '0;
        end else if (cmdFire) begin
            rdAddr_q <= cmd_start;
            rdCnt_q  <= cmd_len;
        end else if (state_q == VERIFY) begin
            rdAddr_q <= rdAddr_q + 1'b1;
            rdCnt_q  <= rdCnt_q - 1'b1;
        end
    end

    assign mem_rd_addr = rdAddr_q;
    assign lastRead    = (state_q == VERIFY) && (rdCnt_q == (ADDR_W+1)'(1));
    // The final read word joins the sum in the same edge that reports the result
    assign mismatch    = wrSum != (rdSum ^ mem_rd_data);
    assign finish      = lastRead;
`else
    logic unusedRdData;
    assign unusedRdData = ^mem_rd_data;
    assign mem_rd_addr  = '0;
    assign lastRead     = 1'b0;
    assign mismatch     = 1'b0;
    assign finish       = (state_q == FLUSH);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmdFire && !lenIllegal) state_d = HALT;
            HALT:    state_d = WRITE;
            WRITE:   if (lastWord) state_d = FLUSH;
`ifdef INSTR_LOADER_VERIFY_EN
            FLUSH:   state_d = VERIFY;
            VERIFY:  if (lastRead) state_d = IDLE;
`else
            FLUSH:   state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state_q == IDLE);
        data_ready = (state_q == WRITE);
        sm_halt    = (state_q != IDLE);
    end

    // An illegal length is accepted but answered immediately with done+error
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            remain_q <= '0;
            wrAddr_q <= '0;
            wrData_q <= '0;
            wrEn_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            wrEn_q <= dataFire;
            done_q <= 1'b0;
            if (cmdFire) begin
                addr_q   <= cmd_start;
                remain_q <= cmd_len;
                done_q   <= lenIllegal;
                error_q  <= lenIllegal;
            end
            if (dataFire) begin
                wrAddr_q <= addr_q;
                wrData_q <= data_in;
                addr_q   <= addr_q + 1'b1;
                remain_q <= remain_q - 1'b1;
            end
            if (finish) begin
                done_q  <= 1'b1;
                error_q <= mismatch;
            end
        end
    end

    assign mem_wr_addr = wrAddr_q;
    assign mem_wr_data = wrData_q;
    assign mem_wr_en   = wrEn_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard testbench for instr_mem_loader with a behavioural 32x16 instruction memory.
module tb_instr_mem_loader;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 16;
`ifdef INSTR_LOADER_VERIFY_EN
   localparam int VerifyOn = 1;
`else
   localparam int VerifyOn = 0;
`endif

   logic              clk;
   logic              reset;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_start;
   logic [ADDR_W:0]   cmd_len;
   logic              data_valid;
   logic              data_ready;
   logic [DATA_W-1:0] data_in;
   logic [ADDR_W-1:0] mem_wr_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic              mem_wr_en;
   logic [ADDR_W-1:0] mem_rd_addr;
   logic [DATA_W-1:0] mem_rd_data;
   logic              sm_halt;
   logic              done;
   logic              error;

   typedef struct {
      int                cyc;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wrExp_t;

   typedef struct {
      int   cyc;
      logic err;
   } doneExp_t;

   wrExp_t      wrQ[$];
   doneExp_t    doneQ[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          corruptCycle = -1;
   logic [DATA_W-1:0] mem [32];

   instr_mem_loader dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_start  (cmd_start),
      .cmd_len    (cmd_len),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .data_in    (data_in),
      .mem_wr_addr(mem_wr_addr),
      .mem_wr_data(mem_wr_data),
      .mem_wr_en  (mem_wr_en),
      .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data),
      .sm_halt    (sm_halt),
      .done       (done),
      .error      (error)
   );

   // Free-running clock and a cycle counter that names the period after each rising edge
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Instruction memory model: registered write port, asynchronous read, optional one-shot corruption
   always @(posedge clk) begin
      if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
      if (cyc == corruptCycle) mem[2] <= 16'hFFFF;
   end

   assign mem_rd_data = mem[mem_rd_addr];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor pops the scoreboard whenever the DUT issues a write or a done pulse
   always @(negedge clk) begin
      if (mem_wr_en === 1'b1) begin
         if (wrQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpectedWrite: got write addr 0x%0h data 0x%0h, expected none (cycle %0d)",
                     mem_wr_addr, mem_wr_data, cyc);
         end else begin
            wrExp_t e;
            e = wrQ.pop_front();
            checkOutput("wrAddr", 32'(mem_wr_addr), 32'(e.addr));
            checkOutput("wrData", 32'(mem_wr_data), 32'(e.data));
            checkOutput("wrCycle", 32'(cyc), 32'(e.cyc));
         end
      end
      if (done === 1'b1) begin
         if (doneQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpectedDone: got done with error=%0b, expected none (cycle %0d)", error, cyc);
         end else begin
            doneExp_t d;
            d = doneQ.pop_front();
            checkOutput("doneCycle", 32'(cyc), 32'(d.cyc));
            checkOutput("doneError", 32'(error), 32'(d.err));
            checkOutput("doneHaltLow", 32'(sm_halt), 32'(0));
            checkOutput("doneCmdReady", 32'(cmd_ready), 32'(1));
         end
      end
   end

   // Issue one command and push the writes and done pulse it should produce
   task automatic applyStimulus(input logic [ADDR_W-1:0] start, input int len, input logic [DATA_W-1:0] base,
                                input bit stall, input int nSent, input bit expErr, input bit expDone,
                                output int k);
      int step;
      @(negedge clk);
      k = cyc;
      step = stall ? 2 : 1;
      if (len >= 1 && len <= 32) begin
         for (int i = 0; i < nSent; i++)
            wrQ.push_back('{k + 3 + i * step, ADDR_W'(int'(start) + i), DATA_W'(int'(base) + i)});
         if (expDone)
            doneQ.push_back('{k + len + 3 + (stall ? len - 1 : 0) + VerifyOn * len, expErr});
      end else if (expDone) begin
         doneQ.push_back('{k + 1, 1'b1});
      end
      cmd_valid = 1'b1;
      cmd_start = start;
      cmd_len   = (ADDR_W+1)'(len);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_start = '0;
      cmd_len   = '0;
   endtask

   task automatic sendWords(input int n, input logic [DATA_W-1:0] base, input bit stall);
      for (int i = 0; i < n; i++) begin
         int to;
         data_valid = 1'b1;
         data_in    = DATA_W'(int'(base) + i);
         to = 0;
         while (data_ready !== 1'b1 && to < 20) begin
            @(negedge clk);
            to++;
         end
         if (to >= 20) begin
            checks++;
            failures++;
            $display("[TB] FAIL dataReadyTimeout: got data_ready=%0b, expected 1 within 20 cycles", data_ready);
            break;
         end
         checkOutput("smHaltWrite", 32'(sm_halt), 32'(1));
         @(negedge clk);
         if (stall && i < n - 1) begin
            data_valid = 1'b0;
            data_in    = 16'hDEAD;
            checkOutput("readyHeldStall", 32'(data_ready), 32'(1));
            @(negedge clk);
         end
      end
      data_valid = 1'b0;
      data_in    = '0;
   endtask

   task automatic waitDone();
      int to;
      to = 0;
      while (doneQ.size() != 0 && to < 300) begin
         @(negedge clk);
         to++;
      end
      if (to >= 300) begin
         checks++;
         failures++;
         $display("[TB] FAIL doneTimeout: got %0d pending done pulses, expected 0", doneQ.size());
         doneQ.delete();
      end
      @(negedge clk);
   endtask

   task automatic runLoad(input logic [ADDR_W-1:0] start, input int len, input logic [DATA_W-1:0] base,
                          input bit stall, input bit corrupt);
      int k;
      applyStimulus(start, len, base, stall, len, corrupt, 1'b1, k);
      if (corrupt) corruptCycle = k + 6;
      checkOutput("haltAfterAccept", 32'(sm_halt), 32'(1));
      checkOutput("cmdReadyLowHalt", 32'(cmd_ready), 32'(0));
      checkOutput("errorCleared", 32'(error), 32'(0));
      sendWords(len, base, stall);
      waitDone();
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_cmdReady"}, 32'(cmd_ready), 32'(1));
      checkOutput({tag, "_dataReady"}, 32'(data_ready), 32'(0));
      checkOutput({tag, "_wrAddr"}, 32'(mem_wr_addr), 32'(0));
      checkOutput({tag, "_wrData"}, 32'(mem_wr_data), 32'(0));
      checkOutput({tag, "_wrEn"}, 32'(mem_wr_en), 32'(0));
      checkOutput({tag, "_rdAddr"}, 32'(mem_rd_addr), 32'(0));
      checkOutput({tag, "_smHalt"}, 32'(sm_halt), 32'(0));
      checkOutput({tag, "_done"}, 32'(done), 32'(0));
      checkOutput({tag, "_error"}, 32'(error), 32'(0));
   endtask

   // Directed sequence: basic load, wrap, illegal lengths, stalls, readback fault, mid-load reset
   initial begin
      int k;
      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_start  = '0;
      cmd_len    = '0;
      data_valid = 1'b0;
      data_in    = '0;
      repeat (3) @(negedge clk);
      checkResetValues("reset");
      reset = 1'b0;
      @(negedge clk);

      runLoad(5'd0, 4, 16'hA001, 1'b0, 1'b0);

      runLoad(5'd30, 4, 16'hC001, 1'b0, 1'b0);
      checkOutput("wrapMem30", 32'(mem[30]), 32'h0000C001);
      checkOutput("wrapMem31", 32'(mem[31]), 32'h0000C002);
      checkOutput("wrapMem0", 32'(mem[0]), 32'h0000C003);
      checkOutput("wrapMem1", 32'(mem[1]), 32'h0000C004);

      applyStimulus(5'd0, 0, 16'h0000, 1'b0, 0, 1'b1, 1'b1, k);
      @(negedge clk);
      applyStimulus(5'd3, 40, 16'h0000, 1'b0, 0, 1'b1, 1'b1, k);
      repeat (3) @(negedge clk);
      checkOutput("errorHeld", 32'(error), 32'(1));
      checkOutput("illegalHaltLow", 32'(sm_halt), 32'(0));

      runLoad(5'd0, 32, 16'hD000, 1'b1, 1'b0);
      checkOutput("stallMem17", 32'(mem[17]), 32'h0000D011);

`ifdef INSTR_LOADER_VERIFY_EN
      runLoad(5'd0, 4, 16'hE001, 1'b0, 1'b1);
      checkOutput("corruptErrorHeld", 32'(error), 32'(1));
`endif

      applyStimulus(5'd0, 5, 16'hB001, 1'b0, 2, 1'b0, 1'b0, k);
      sendWords(2, 16'hB001, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      checkResetValues("midReset");
      reset = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("keepMem0", 32'(mem[0]), 32'h0000B001);
      checkOutput("keepMem1", 32'(mem[1]), 32'h0000B002);
      checkOutput("idleAfterReset", 32'(cmd_ready), 32'(1));

      checkOutput("wrQueueEmpty", 32'(wrQ.size()), 32'(0));
      checkOutput("doneQueueEmpty", 32'(doneQ.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   // Guard against a hung handshake anywhere in the sequence
   initial begin
      #500000;
      failures++;
      $display("[TB] FAIL watchdog: got no completion, expected finish within 50000 cycles");
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Program-load controller for the PIO instruction memory. Accepts a load command (start address, word count) from the host side, halts the state machines, and streams 16-bit instruction words into the memory's single write port over a valid/ready handshake. Optionally reads the loaded region back through the memory's PIO read port and checks it. Sits between the host/bus interface and the instruction memory, next to the state-machine enable logic.

## Interface
Parameters:
- ADDR_W, 5, instruction memory address width (depth = 2**ADDR_W = 32)
- DATA_W, 16, instruction word width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  load command present
- cmd_ready  out  1  high only in IDLE
- cmd_start  in  ADDR_W  first address to write
- cmd_len  in  ADDR_W+1  word count, legal 1..32
- data_valid  in  1  instruction word present
- data_ready  out  1  high only in WRITE
- data_in  in  DATA_W  instruction word
- mem_wr_addr  out  ADDR_W  to memory writeAddress, registered
- mem_wr_data  out  DATA_W  to memory writeData, registered
- mem_wr_en  out  1  to memory writeEnable, registered, 1-cycle pulse per word
- mem_rd_addr  out  ADDR_W  to memory pioAddress
- mem_rd_data  in  DATA_W  from memory pioData, asynchronous
- sm_halt  out  1  high in every state except IDLE
- done  out  1  1-cycle pulse, load finished
- error  out  1  valid with done; held until next accepted command

## Operation
- States: IDLE, HALT, WRITE, FLUSH, VERIFY (VERIFY only with macro).
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready: latch start/len, clear checksum and error, go HALT. If cmd_len==0 or >32: no writes; stay IDLE, pulse done with error=1 next cycle.
- HALT: one cycle, lets state machines quiesce; go WRITE.
- WRITE: data_ready=1. Each data_valid&&data_ready registers mem_wr_addr=addr, mem_wr_data=data_in, mem_wr_en=1; addr increments mod 32 (31 wraps to 0); remaining count decrements; data_in XORed into write checksum. data_valid low: stall, mem_wr_en=0. After last word go FLUSH.
- FLUSH: one cycle, last write lands in memory. Go VERIFY (macro on) or IDLE with done=1.
- VERIFY: mem_rd_addr steps from cmd_start for len cycles (wrapping); mem_rd_data XORed into read checksum each cycle. After last cycle: go IDLE, done=1, error = (write checksum != read checksum).
- data_valid outside WRITE ignored; cmd_valid outside IDLE ignored.
- Reset mid-operation: return IDLE; words already written stay in memory; no done pulse.

## Timing
- Reset values: cmd_ready=1, data_ready=0, mem_wr_addr=0, mem_wr_data=0, mem_wr_en=0, mem_rd_addr=0, sm_halt=0, done=0, error=0.
- Command accepted at edge k: sm_halt=1 from cycle k+1; HALT cycle k+1; WRITE from k+2.
- Continuous data, N words: handshakes in cycles k+2..k+N+1; mem_wr_en high k+3..k+N+2; FLUSH at k+N+2.
- Macro off: done high (sm_halt=0, cmd_ready=1) in cycle k+N+3.
- Macro on: VERIFY cycles k+N+3..k+2N+2; done in k+2N+3.
- Each stall cycle in WRITE delays everything after it by one cycle.
- A new command may be accepted in the same cycle done is high.

## Configuration
- INSTR_LOADER_VERIFY_EN defined: VERIFY state, checksums and readback present; error flags readback mismatch or illegal length.
- Not defined: VERIFY and checksums omitted, mem_rd_addr tied 0, FLUSH goes straight to IDLE; error flags only illegal length.

## Structure
- Package instr_loader_pkg: state encoding (IDLE, HALT, WRITE, FLUSH, VERIFY), IMEM_DEPTH=32, default ADDR_W/DATA_W, MAX_LEN=32.
- One sub-module: loader_checksum (clear, enable, DATA_W XOR accumulator), instantiated twice under the macro.

## Test plan
- Reset, then cmd_start=0, cmd_len=4, words 0xA001..0xA004 back-to-back -> mem_wr_en pulses addresses 0..3 in cycles k+3..k+6; done at k+7 (macro off) or k+11 (on), error=0.
- cmd_start=30, cmd_len=4 -> writes to addresses 30, 31, 0, 1; verify reads the same order; error=0.
- cmd_len=32 with data_valid low every other cycle -> data_ready held, 32 writes, done after stalls added; sm_halt high throughout.
- cmd_len=0, then cmd_len=40 -> no mem_wr_en; done=1, error=1 cycle after each accept.
- Macro on: force memory word at addr 2 to 0xFFFF after its write -> done with error=1.
- Assert reset in WRITE after 2 of 5 words -> all outputs to reset values next cycle, no done; addresses 0..1 keep written data.
